i2c_master_ctrl: RTL and testbench
==================================

# i2c_master_ctrl

Synthesizable I2C bus master that initiates single-address transactions (START, 7-bit address + op bit, N data bytes, STOP). It is the initiator counterpart to the I2C slave BFM in the verification IP. It is driven by a simple command handshake from a host-side controller and drives open-drain SCL/SDA through release/low enables. It uses the same op encoding as the slave side: WRITE = 0, READ = 1.

## Interface
- CLK_DIV, 25 — system clocks per SCL quarter-period; legal values ≥ 2.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle, command accepted when cmd_valid && cmd_ready
- cmd_addr  in  7  slave address
- cmd_op  in  1  0 = WRITE, 1 = READ
- cmd_len  in  4  data byte count, 0–15 (0 = address-only ping)
- wr_data  in  8  write byte, sampled in the cycle wr_req = 1
- wr_req  out  1  one-cycle pulse requesting the next write byte
- rd_data  out  8  last received byte, held until next rd_valid
- rd_valid  out  1  one-cycle pulse, rd_data updated
- done  out  1  one-cycle pulse at transaction end
- nack  out  1  valid with done; 1 = slave NACKed address or a write byte
- busy  out  1  transaction in progress (state ≠ IDLE)
- scl_o  out  1  1 = release SCL, 0 = drive low
- sda_o  out  1  1 = release SDA, 0 = drive low
- scl_i  in  1  sensed SCL, for clock stretching
- sda_i  in  1  sensed SDA

## Operation
- FSM states: IDLE, START, ADDR, SEND, RECEIVE, STOP.
- Every bus step is 4 quarters (q0–q3) of CLK_DIV clocks each, timed by a divide counter and a 2-bit quarter counter.
- IDLE: cmd_ready = 1. On accept, latch addr/op/len and go to START on the next cycle.
- START quarters (SDA/SCL): q0 rel/rel, q1 rel/rel, q2 low/rel, q3 low/low. Then ADDR.
- Data bit, 9 per byte, MSB first:
  - q0: SCL low, set sda_o.
  - q1 and q2: SCL released.
  - sda_i is sampled on the last clock of q2.
  - q3: SCL released; SCL goes low at the next q0.
- ADDR shifts {cmd_addr, cmd_op}; bit 9 releases SDA and samples ACK (sda_i = 0).
  - On NACK, set nack and go to STOP.
  - On ACK with len = 0, go to STOP.
  - Otherwise go to SEND (WRITE) or RECEIVE (READ).
- SEND: wr_req pulses on the first cycle of bit 1, and wr_data is loaded that cycle. Bit 9 samples ACK.
  - On NACK, set nack and go to STOP without sending remaining bytes.
  - After the byte count is exhausted, go to STOP.
- RECEIVE: SDA is released for bits 1–8 and shifted in.
  - rd_data/rd_valid update on the cycle after the bit-8 sample.
  - Bit 9: master drives ACK (sda_o = 0) for every byte except the last, then NACK (released) on the last.
- STOP quarters: q0 low/low, q1 low/rel, q2 low/rel, q3 rel/rel.
  - done pulses on the final clock of q3, with nack valid in that cycle.
  - The FSM enters IDLE the next cycle.
- Clock stretching: in q1, the divide counter holds at 0 while scl_i = 0. Timing resumes when scl_i = 1. This applies in START/STOP too.
- cmd_valid is ignored while busy. There is no multi-master arbitration.

## Timing
- Reset values: scl_o = 1, sda_o = 1, cmd_ready = 1, busy = 0, wr_req = 0, rd_valid = 0, rd_data = 0, done = 0, nack = 0. The FSM is IDLE with counters at 0.
- rst asserted mid-transaction releases both lines immediately (asynchronously). No STOP is generated.
- Latency without stretching: command accepted at cycle C → START q0 begins at C+1.
  - done occurs at C + CLK_DIV × (8 + 36 × (1 + len)).
- nack is cleared at accept and is meaningful only while done = 1.
- busy = 1 from C+1 through the done cycle. cmd_ready is low during the same span.
- SDA changes only in q0 of data bits, or at defined START/STOP quarters, so SDA is never changed while SCL is high except in START/STOP.

## Test plan
- WRITE addr 0x22, len 2, data 0xA5, 0x3C, slave ACKs all:
  - SDA bytes 0x44, 0xA5, 0x3C.
  - Exactly 2 wr_req pulses.
  - done at C + 25 × 116 = C + 2900 with nack = 0.
- READ addr 0x22, len 3, slave returns 0x11, 0x22, 0x33:
  - 3 rd_valid pulses with those values.
  - Master ACK bits 0, 0, then released (NACK).
  - done with nack = 0.
- Address NACK with len 4, plus a separate len = 0 ping that is ACKed:
  - NACK case: no wr_req, STOP generated, done with nack = 1.
  - Ping case: done with nack = 0 after 44 quarters.
- WRITE len 3, slave NACKs byte 1:
  - Exactly 1 wr_req.
  - STOP follows bit 9 of byte 1.
  - nack = 1.
- Slave holds scl_i low 100 cycles during the address ACK bit:
  - done is delayed by exactly 100 cycles.
  - Data and ACK are correct.
- rst asserted mid-RECEIVE:
  - All outputs take reset values in the same cycle.
  - After release, cmd_ready = 1 and a new WRITE completes normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-address I2C bus master: START, address+op, up to 15 data bytes, STOP.
// Each bus step is four quarters of CLK_DIV clocks; SCL/SDA are open-drain release enables.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_op,
    input  logic [3:0] cmd_len,
    input  logic [7:0] wr_data,
    output logic       wr_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       nack,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, ADDR, SEND, RECEIVE, STOP} state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       q_reg;
    logic [3:0]       bit_reg;       // 0..7 data bits, 8 = ACK slot
    logic [3:0]       byte_cnt_reg;  // bytes still to transfer
    logic             op_reg;
    logic [7:0]       tx_reg;
    logic [7:0]       rx_reg;
    logic [7:0]       rd_data_reg;
    logic             rd_valid_reg;
    logic             ack_bit_reg;   // SDA level seen in the ACK slot, 1 = NACK
    logic             nack_reg;

    logic accept, stretch_hold, quarter_end, step_end, sample_pt, last_bit, in_data;

    assign accept       = cmd_valid && (state_reg == IDLE);
    // A slave holding SCL low freezes timing at the start of the SCL-high window.
    assign stretch_hold = (state_reg != IDLE) && (q_reg == 2'd1) && (div_reg == '0) && !scl_i;
    assign quarter_end  = (div_reg == DIV_LAST) && !stretch_hold;
    assign step_end     = quarter_end && (q_reg == 2'd3);
    assign sample_pt    = quarter_end && (q_reg == 2'd2);
    assign last_bit     = (bit_reg == 4'd8);
    assign in_data      = (state_reg == ADDR) || (state_reg == SEND) || (state_reg == RECEIVE);

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign wr_req    = (state_reg == SEND) && (bit_reg == 4'd0) && (q_reg == 2'd0) && (div_reg == '0);
    assign done      = (state_reg == STOP) && step_end;
    assign nack      = nack_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        scl_o      = 1'b1;
        sda_o      = 1'b1;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) state_next = START;
            end
            START: begin
                sda_o = ~q_reg[1];
                scl_o = (q_reg != 2'd3);
                if (step_end) state_next = ADDR;
            end
            ADDR: begin
                scl_o = (q_reg != 2'd0);
                sda_o = last_bit ? 1'b1 : tx_reg[7];
                if (step_end && last_bit) begin
                    if (ack_bit_reg || (byte_cnt_reg == 4'd0)) state_next = STOP;
                    else if (op_reg)                           state_next = RECEIVE;
                    else                                       state_next = SEND;
                end
            end
            SEND: begin
                scl_o = (q_reg != 2'd0);
                sda_o = last_bit ? 1'b1 : tx_reg[7];
                if (step_end && last_bit && (ack_bit_reg || (byte_cnt_reg == 4'd1)))
                    state_next = STOP;
            end
            RECEIVE: begin
                scl_o = (q_reg != 2'd0);
                // Master ACKs every byte but the last, which it NACKs by releasing SDA.
                sda_o = last_bit ? (byte_cnt_reg == 4'd1) : 1'b1;
                if (step_end && last_bit && (byte_cnt_reg == 4'd1))
                    state_next = STOP;
            end
            STOP: begin
                scl_o = (q_reg != 2'd0);
                sda_o = (q_reg == 2'd3);
                if (step_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg      <= '0;
            q_reg        <= 2'd0;
            bit_reg      <= 4'd0;
            byte_cnt_reg <= 4'd0;
            op_reg       <= 1'b0;
            tx_reg       <= 8'h00;
            rx_reg       <= 8'h00;
            rd_data_reg  <= 8'h00;
            rd_valid_reg <= 1'b0;
            ack_bit_reg  <= 1'b0;
            nack_reg     <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;

            if (state_reg == IDLE) begin
                div_reg <= '0;
                q_reg   <= 2'd0;
                bit_reg <= 4'd0;
            end else if (!stretch_hold) begin
                if (quarter_end) begin
                    div_reg <= '0;
                    q_reg   <= q_reg + 2'd1;
                end else begin
                    div_reg <= div_reg + DIV_W'(1);
                end
            end

            if (step_end && in_data)
                bit_reg <= last_bit ? 4'd0 : bit_reg + 4'd1;

            if (accept) begin
                tx_reg       <= {cmd_addr, cmd_op};
                byte_cnt_reg <= cmd_len;
                op_reg       <= cmd_op;
                nack_reg     <= 1'b0;
            end

            // Shifting in ones leaves SDA released between the last data bit and the next load.
            if (wr_req)
                tx_reg <= wr_data;
            else if (step_end && !last_bit && ((state_reg == ADDR) || (state_reg == SEND)))
                tx_reg <= {tx_reg[6:0], 1'b1};

            if (sample_pt && in_data) begin
                if (last_bit) begin
                    ack_bit_reg <= sda_i;
                end else if (state_reg == RECEIVE) begin
                    rx_reg <= {rx_reg[6:0], sda_i};
                    if (bit_reg == 4'd7) begin
                        rd_data_reg  <= {rx_reg[6:0], sda_i};
                        rd_valid_reg <= 1'b1;
                    end
                end
            end

            if (step_end && last_bit) begin
                if (((state_reg == ADDR) || (state_reg == SEND)) && ack_bit_reg)
                    nack_reg <= 1'b1;
                if ((state_reg == SEND) || (state_reg == RECEIVE))
                    byte_cnt_reg <= byte_cnt_reg - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a clock-sampled behavioural I2C slave on the bus.
module tb_i2c_master_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = 7'h00;
    logic       cmd_op = 1'b0;
    logic [3:0] cmd_len = 4'd0;
    logic [7:0] wr_data;
    logic       wr_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       nack;
    logic       busy;
    logic       scl_o;
    logic       sda_o;
    logic       scl_i;
    logic       sda_i;

    logic       stretch = 1'b0;
    logic       slv_sda = 1'b1;

    i2c_master_ctrl #(.CLK_DIV(25)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_req    (wr_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .nack      (nack),
        .busy      (busy),
        .scl_o     (scl_o),
        .sda_o     (sda_o),
        .scl_i     (scl_i),
        .sda_i     (sda_i)
    );

    initial forever #5 clk = ~clk;

    // Wired-AND bus: master release enable AND slave drive / stretch.
    assign scl_i = scl_o & ~stretch;
    assign sda_i = sda_o & slv_sda;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write data source and bookkeeping
    logic [7:0] wr_vals [4];
    logic [7:0] rd_vals [4];
    int wr_total = 0;
    int wr_base = 0;
    int nack_at = -1;
    assign wr_data = wr_vals[(wr_total - wr_base) & 3];

    always @(posedge clk) if (wr_req) wr_total <= wr_total + 1;

    logic [7:0] rdv_q[$];
    logic [7:0] rx_q[$];
    logic       mack_q[$];
    int stop_total = 0;
    always @(negedge clk) if (rd_valid) rdv_q.push_back(rd_data);

    // Slave: samples the bus mid-cycle, so simultaneous SCL/SDA changes never look like START/STOP.
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       sl_active = 1'b0;
    logic       sl_read = 1'b0;
    int         sl_cnt = 0;
    int         sl_byte = 0;
    logic [7:0] sl_sh = 8'h00;

    always @(negedge clk) begin
        p_scl <= scl_i;
        p_sda <= sda_i;
        if (rst) begin
            sl_active <= 1'b0;
            slv_sda   <= 1'b1;
            sl_cnt    <= 0;
            sl_byte   <= 0;
            sl_read   <= 1'b0;
        end else if (p_scl && scl_i && p_sda && !sda_i) begin
            sl_active <= 1'b1;
            sl_cnt    <= 0;
            sl_byte   <= 0;
            sl_read   <= 1'b0;
            slv_sda   <= 1'b1;
        end else if (p_scl && scl_i && !p_sda && sda_i) begin
            stop_total <= stop_total + 1;
            sl_active  <= 1'b0;
            slv_sda    <= 1'b1;
        end else if (!p_scl && scl_i && sl_active) begin
            if (sl_cnt < 8) begin
                sl_sh  <= {sl_sh[6:0], sda_i};
                sl_cnt <= sl_cnt + 1;
            end else begin
                sl_cnt  <= 0;
                sl_byte <= sl_byte + 1;
                if (sl_byte == 0) begin
                    rx_q.push_back(sl_sh);
                    sl_read <= sl_sh[0];
                    if (nack_at == 0) sl_active <= 1'b0;
                end else if (sl_read) begin
                    mack_q.push_back(sda_i);
                    if (sda_i) sl_active <= 1'b0;
                end else begin
                    rx_q.push_back(sl_sh);
                    if (nack_at == sl_byte) sl_active <= 1'b0;
                end
            end
        end else if (p_scl && !scl_i) begin
            if (!sl_active)
                slv_sda <= 1'b1;
            else if (sl_cnt == 8 && (sl_byte == 0 || !sl_read))
                slv_sda <= (nack_at == sl_byte) ? 1'b1 : 1'b0;
            else if (sl_cnt < 8 && sl_read && sl_byte > 0)
                slv_sda <= rd_vals[sl_byte-1][7-sl_cnt];
            else
                slv_sda <= 1'b1;
        end
    end

    int rx_base, rdv_base, mack_base, stop_base;

    task automatic snap();
        wr_base   = wr_total;
        rx_base   = rx_q.size();
        rdv_base  = rdv_q.size();
        mack_base = mack_q.size();
        stop_base = stop_total;
    endtask

    // Issue one command; cycle 1 is the first START cycle, done expected at cycle exp_cyc.
    task automatic run_cmd(input string tag, input logic [6:0] a, input logic op,
                           input logic [3:0] len, input int exp_cyc, input logic exp_nack,
                           input int stretch_at);
        int  k;
        bit  got;
        @(negedge clk);
        cmd_addr  = a;
        cmd_op    = op;
        cmd_len   = len;
        cmd_valid = 1'b1;
        check({tag, "_ready"}, cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready_lo"}, cmd_ready, 0);
        got = 0;
        while (!got && k <= 6000) begin
            if (stretch_at != 0 && k == stretch_at)       stretch = 1'b1;
            if (stretch_at != 0 && k == stretch_at + 100) stretch = 1'b0;
            if (done) begin
                got = 1;
                check({tag, "_cycles"}, k, exp_cyc);
                check({tag, "_nack"}, nack, exp_nack);
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
        stretch = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, busy, 0);
        $display("%s: addr 0x%02h op %0d len %0d, done at cycle %0d, nack %0d",
                 tag, a, op, len, k, nack);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 4; i++) begin
            wr_vals[i] = 8'h00;
            rd_vals[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_scl", scl_o, 1);
        check("rst_sda", sda_o, 1);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write two bytes, all ACKed
        nack_at = -1; wr_vals[0] = 8'hA5; wr_vals[1] = 8'h3C; snap();
        run_cmd("wr2", 7'h22, 1'b0, 4'd2, 2900, 1'b0, 0);
        check("wr2_wrreq", wr_total - wr_base, 2);
        check("wr2_nbytes", rx_q.size() - rx_base, 3);
        check("wr2_b0", rx_q[rx_base], 8'h44);
        check("wr2_b1", rx_q[rx_base+1], 8'hA5);
        check("wr2_b2", rx_q[rx_base+2], 8'h3C);
        check("wr2_stop", stop_total - stop_base, 1);

        // Read three bytes
        rd_vals[0] = 8'h11; rd_vals[1] = 8'h22; rd_vals[2] = 8'h33; snap();
        run_cmd("rd3", 7'h22, 1'b1, 4'd3, 3800, 1'b0, 0);
        check("rd3_addr", rx_q[rx_base], 8'h45);
        check("rd3_wrreq", wr_total - wr_base, 0);
        check("rd3_nvalid", rdv_q.size() - rdv_base, 3);
        check("rd3_d0", rdv_q[rdv_base], 8'h11);
        check("rd3_d1", rdv_q[rdv_base+1], 8'h22);
        check("rd3_d2", rdv_q[rdv_base+2], 8'h33);
        check("rd3_mack0", mack_q[mack_base], 0);
        check("rd3_mack1", mack_q[mack_base+1], 0);
        check("rd3_mack2", mack_q[mack_base+2], 1);
        check("rd3_hold", rd_data, 8'h33);

        // Address NACK with len 4
        nack_at = 0; snap();
        run_cmd("anak", 7'h5C, 1'b0, 4'd4, 1100, 1'b1, 0);
        check("anak_wrreq", wr_total - wr_base, 0);
        check("anak_addr", rx_q[rx_base], 8'hB8);
        check("anak_stop", stop_total - stop_base, 1);

        // Address-only ping
        nack_at = -1; snap();
        run_cmd("ping", 7'h3B, 1'b0, 4'd0, 1100, 1'b0, 0);
        check("ping_addr", rx_q[rx_base], 8'h76);
        check("ping_stop", stop_total - stop_base, 1);

        // Write three, slave NACKs the first data byte
        nack_at = 1; wr_vals[0] = 8'h81; wr_vals[1] = 8'h42; wr_vals[2] = 8'h18; snap();
        run_cmd("wnak", 7'h10, 1'b0, 4'd3, 2000, 1'b1, 0);
        check("wnak_wrreq", wr_total - wr_base, 1);
        check("wnak_nbytes", rx_q.size() - rx_base, 2);
        check("wnak_b1", rx_q[rx_base+1], 8'h81);
        check("wnak_stop", stop_total - stop_base, 1);

        // 100-cycle stretch starting at the first SCL-high cycle of the address ACK bit
        nack_at = -1; wr_vals[0] = 8'hC3; snap();
        run_cmd("strc", 7'h50, 1'b0, 4'd1, 2100, 1'b0, 926);
        check("strc_b0", rx_q[rx_base], 8'hA0);
        check("strc_b1", rx_q[rx_base+1], 8'hC3);

        // Reset during the master ACK slot of the first received byte
        rd_vals[0] = 8'h5A; rd_vals[1] = 8'h96; snap();
        @(negedge clk);
        cmd_addr = 7'h2D; cmd_op = 1'b1; cmd_len = 4'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!rd_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("rstm_rd0", rd_data, 8'h5A);
        repeat (30) @(negedge clk);
        check("rstm_pre_scl", scl_o, 0);
        check("rstm_pre_sda", sda_o, 0);
        rst = 1'b1;
        #1;
        check("rstm_scl", scl_o, 1);
        check("rstm_sda", sda_o, 1);
        check("rstm_ready", cmd_ready, 1);
        check("rstm_busy", busy, 0);
        check("rstm_rd_data", rd_data, 0);
        check("rstm_outs", {wr_req, rd_valid, done, nack}, 0);
        $display("rstm: addr 0x2d read reset mid-receive");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstm_ready_after", cmd_ready, 1);

        wr_vals[0] = 8'h7E; snap();
        run_cmd("post", 7'h41, 1'b0, 4'd1, 2000, 1'b0, 0);
        check("post_b0", rx_q[rx_base], 8'h82);
        check("post_b1", rx_q[rx_base+1], 8'h7E);
        check("post_wrreq", wr_total - wr_base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
